// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, line levels and a parity helper.
// Imported by both the transmitter and the receiver so framing stays consistent.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Word is zero-extended to 9 bits; the padding does not change the XOR.
  function automatic logic parity_bit(input parity_e mode, input logic [8:0] word);
    return (mode == PARITY_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock FIFO; head word is visible on pop_dat with zero latency, push/pop take effect at the edge.
// Push while full is ignored, pop while empty is ignored; full/empty/level come from registered occupancy.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a TX FIFO; line outputs are registered one clk behind the FSM (write->start bit = 2 clks).
// Writes while full are dropped and raise sticky error; enable low aborts the frame but keeps queued words.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          write,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          clear_error,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam parity_e PAR_MODE = parity_e'(PARITY_MODE[1:0]);

  tx_state_e            state, state_n;
  logic [DIV_W-1:0]     div_cnt, div_n;
  logic [BIT_W-1:0]     bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 par_reg, par_n;
  logic                 tx_n, busy_n, done_n;
  logic                 bit_end, start_frame;
  logic                 fifo_pop, fifo_empty;
  logic [DATA_BITS-1:0] fifo_dat;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (write),
    .push_dat (data),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign bit_end = (div_cnt == DIV_LAST);

  always_comb begin
    state_n     = state;
    div_n       = div_cnt;
    bit_n       = bit_idx;
    shift_n     = shift_reg;
    par_n       = par_reg;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
    tx_n        = LINE_IDLE;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    if (state != TX_IDLE) div_n = bit_end ? '0 : div_cnt + 1'b1;
    case (state)
      TX_IDLE: start_frame = enable && !fifo_empty;
      TX_START: begin
        tx_n   = START_BIT;
        busy_n = 1'b1;
        if (bit_end) begin
          state_n = TX_DATA;
          bit_n   = '0;
        end
      end
      TX_DATA: begin
        tx_n   = shift_reg[0];
        busy_n = 1'b1;
        if (bit_end) begin
          shift_n = shift_reg >> 1;
          if (bit_idx == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PAR_MODE == PARITY_NONE) ? TX_STOP : TX_PARITY;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        tx_n   = par_reg;
        busy_n = 1'b1;
        if (bit_end) state_n = TX_STOP;
      end
      TX_STOP: begin
        tx_n   = STOP_BIT;
        busy_n = 1'b1;
        if (bit_end) begin
          if (bit_idx == STOP_LAST) begin
            done_n      = 1'b1;
            start_frame = enable && !fifo_empty;
            state_n     = TX_IDLE;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      default: state_n = TX_IDLE;
    endcase
    // Parity is captured at load time because the data shifts out destructively.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_n  = fifo_dat;
      par_n    = parity_bit(PAR_MODE, 9'(fifo_dat));
      bit_n    = '0;
      div_n    = '0;
      state_n  = TX_START;
    end
    if (state != TX_IDLE && !enable) begin
      state_n  = TX_IDLE;
      div_n    = '0;
      bit_n    = '0;
      fifo_pop = 1'b0;
      tx_n     = LINE_IDLE;
      busy_n   = 1'b0;
      done_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_IDLE;
      div_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx        <= LINE_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      bit_idx   <= bit_n;
      shift_reg <= shift_n;
      par_reg   <= par_n;
      tx        <= tx_n;
      busy      <= busy_n;
      done      <= done_n;
      if (write && full)    error <= 1'b1;
      else if (clear_error) error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: even-parity main instance plus odd/2-stop and no-parity instances, frames checked clk by clk.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clear_error;
  logic [7:0] data;
  logic [2:0] wr_v;
  logic [2:0] full_v, tx_v, busy_v, done_v, err_v;
  logic [2:0] level0;
  logic [3:0] level1, level2;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .write(wr_v[0]), .data(data), .clear_error(clear_error),
    .full(full_v[0]), .level(level0), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(8)) dut_odd (
    .clk(clk), .rst(rst), .enable(enable), .write(wr_v[1]), .data(data), .clear_error(clear_error),
    .full(full_v[1]), .level(level1), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_np (
    .clk(clk), .rst(rst), .enable(enable), .write(wr_v[2]), .data(data), .clear_error(clear_error),
    .full(full_v[2]), .level(level2), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .error(err_v[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] val);
    data    = val;
    wr_v[d] = 1'b1;
    tick();
    wr_v    = '0;
  endtask

  // bits[0] is the start bit; each bit must hold for 4 clks, done only on the final clk.
  task automatic check_bits(input int d, input logic [15:0] bits, input int nbits, input string tag);
    for (int c = 0; c < nbits * 4; c++) begin
      tick();
      chk({tag, "_tx"}, 32'(tx_v[d]), 32'(bits[c / 4]));
      chk({tag, "_busy"}, 32'(busy_v[d]), 32'd1);
      chk({tag, "_done"}, 32'(done_v[d]), 32'(c == nbits * 4 - 1));
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear_error = 1'b0; data = '0; wr_v = '0;
    tick(); tick();
    chk("rst_tx", 32'(tx_v), 32'h7);
    chk("rst_busy", 32'(busy_v), 32'h0);
    chk("rst_done", 32'(done_v), 32'h0);
    chk("rst_err", 32'(err_v), 32'h0);
    chk("rst_full", 32'(full_v), 32'h0);
    chk("rst_lvl0", 32'(level0), 32'd0);
    chk("rst_lvl1", 32'(level1), 32'd0);
    chk("rst_lvl2", 32'(level2), 32'd0);
    rst = 1'b0; enable = 1'b1;
    tick();

    // single even-parity frame
    push(0, 8'h55);
    chk("t1_lvl_n", 32'(level0), 32'd1);
    tick();
    chk("t1_lvl_pop", 32'(level0), 32'd0);
    chk("t1_tx_n1", 32'(tx_v[0]), 32'd1);
    chk("t1_busy_n1", 32'(busy_v[0]), 32'd0);
    check_bits(0, {1'b1, 1'b0, 8'h55, 1'b0}, 11, "t1");
    tick();
    chk("t1_idle_tx", 32'(tx_v[0]), 32'd1);
    chk("t1_idle_busy", 32'(busy_v[0]), 32'd0);
    chk("t1_idle_done", 32'(done_v[0]), 32'd0);

    // odd parity with two stop bits, then no parity
    push(1, 8'hA5);
    chk("t2o_lvl", 32'(level1), 32'd1);
    tick();
    chk("t2o_lvl_pop", 32'(level1), 32'd0);
    chk("t2o_tx_n1", 32'(tx_v[1]), 32'd1);
    check_bits(1, {2'b11, 1'b1, 8'hA5, 1'b0}, 12, "t2o");
    tick();
    chk("t2o_idle", 32'(busy_v[1]), 32'd0);
    push(2, 8'hA5);
    chk("t2n_lvl", 32'(level2), 32'd1);
    tick();
    chk("t2n_lvl_pop", 32'(level2), 32'd0);
    check_bits(2, {1'b1, 8'hA5, 1'b0}, 10, "t2n");
    tick();
    chk("t2n_idle", 32'(busy_v[2]), 32'd0);
    chk("t2n_idle_tx", 32'(tx_v[2]), 32'd1);

    // three queued words go out back-to-back
    enable = 1'b0;
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
    chk("t3_lvl3", 32'(level0), 32'd3);
    enable = 1'b1;
    tick();
    chk("t3_lvl2", 32'(level0), 32'd2);
    chk("t3_tx_n1", 32'(tx_v[0]), 32'd1);
    check_bits(0, {1'b1, 1'b1, 8'h01, 1'b0}, 11, "t3a");
    chk("t3_lvl1", 32'(level0), 32'd1);
    check_bits(0, {1'b1, 1'b1, 8'h02, 1'b0}, 11, "t3b");
    chk("t3_lvl0", 32'(level0), 32'd0);
    check_bits(0, {1'b1, 1'b0, 8'h03, 1'b0}, 11, "t3c");
    tick();
    chk("t3_idle_busy", 32'(busy_v[0]), 32'd0);
    chk("t3_idle_tx", 32'(tx_v[0]), 32'd1);

    // overflow, clear, set-wins, push dropped during a pop
    enable = 1'b0;
    push(0, 8'h10); push(0, 8'h11); push(0, 8'h12); push(0, 8'h13);
    chk("t4_lvl4", 32'(level0), 32'd4);
    chk("t4_full", 32'(full_v[0]), 32'd1);
    chk("t4_err0", 32'(err_v[0]), 32'd0);
    push(0, 8'h14);
    chk("t4_err_ovf", 32'(err_v[0]), 32'd1);
    chk("t4_lvl_ovf", 32'(level0), 32'd4);
    clear_error = 1'b1; tick(); clear_error = 1'b0;
    chk("t4_err_clr", 32'(err_v[0]), 32'd0);
    clear_error = 1'b1; push(0, 8'h15); clear_error = 1'b0;
    chk("t4_set_wins", 32'(err_v[0]), 32'd1);
    clear_error = 1'b1; tick(); clear_error = 1'b0;
    chk("t4_err_clr2", 32'(err_v[0]), 32'd0);
    enable = 1'b1;
    push(0, 8'h16);
    chk("t4_err_pop", 32'(err_v[0]), 32'd1);
    chk("t4_lvl_pop", 32'(level0), 32'd3);
    chk("t4_full_pop", 32'(full_v[0]), 32'd0);
    check_bits(0, {1'b1, 1'b1, 8'h10, 1'b0}, 11, "t4a");
    check_bits(0, {1'b1, 1'b0, 8'h11, 1'b0}, 11, "t4b");
    check_bits(0, {1'b1, 1'b0, 8'h12, 1'b0}, 11, "t4c");
    check_bits(0, {1'b1, 1'b1, 8'h13, 1'b0}, 11, "t4d");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_tail_tx", 32'(tx_v[0]), 32'd1);
      chk("t4_tail_done", 32'(done_v[0]), 32'd0);
    end
    chk("t4_tail_lvl", 32'(level0), 32'd0);
    clear_error = 1'b1; tick(); clear_error = 1'b0;

    // abort mid-DATA, then resume with the next queued word
    enable = 1'b0;
    push(0, 8'h3C); push(0, 8'h5A);
    chk("t5_lvl2", 32'(level0), 32'd2);
    enable = 1'b1;
    tick();
    repeat (10) tick();
    chk("t5_mid_busy", 32'(busy_v[0]), 32'd1);
    chk("t5_mid_tx", 32'(tx_v[0]), 32'd0);
    enable = 1'b0;
    tick();
    chk("t5_abort_tx", 32'(tx_v[0]), 32'd1);
    chk("t5_abort_busy", 32'(busy_v[0]), 32'd0);
    chk("t5_abort_done", 32'(done_v[0]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_off_done", 32'(done_v[0]), 32'd0);
      chk("t5_off_tx", 32'(tx_v[0]), 32'd1);
    end
    chk("t5_lvl_kept", 32'(level0), 32'd1);
    enable = 1'b1;
    push(0, 8'h99);
    chk("t5_pushpop_lvl", 32'(level0), 32'd1);
    chk("t5_tx_n1", 32'(tx_v[0]), 32'd1);
    check_bits(0, {1'b1, 1'b0, 8'h5A, 1'b0}, 11, "t5a");
    check_bits(0, {1'b1, 1'b0, 8'h99, 1'b0}, 11, "t5b");
    tick();
    chk("t5_idle_busy", 32'(busy_v[0]), 32'd0);
    chk("t5_idle_lvl", 32'(level0), 32'd0);

    // asynchronous reset in the middle of a frame
    enable = 1'b0;
    push(0, 8'h21); push(0, 8'h22); push(0, 8'h23); push(0, 8'h24); push(0, 8'h25);
    chk("t6_err_pre", 32'(err_v[0]), 32'd1);
    enable = 1'b1;
    repeat (15) tick();
    chk("t6_busy_pre", 32'(busy_v[0]), 32'd1);
    chk("t6_tx_pre", 32'(tx_v[0]), 32'd0);
    chk("t6_lvl_pre", 32'(level0), 32'd3);
    rst = 1'b1;
    #2;
    chk("t6_rst_tx", 32'(tx_v[0]), 32'd1);
    chk("t6_rst_lvl", 32'(level0), 32'd0);
    chk("t6_rst_busy", 32'(busy_v[0]), 32'd0);
    chk("t6_rst_done", 32'(done_v[0]), 32'd0);
    chk("t6_rst_err", 32'(err_v[0]), 32'd0);
    chk("t6_rst_full", 32'(full_v[0]), 32'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_idle_tx", 32'(tx_v[0]), 32'd1);
      chk("t6_idle_busy", 32'(busy_v[0]), 32'd0);
    end
    push(0, 8'h81);
    chk("t6_lvl_w", 32'(level0), 32'd1);
    tick();
    chk("t6_lvl_pop", 32'(level0), 32'd0);
    check_bits(0, {1'b1, 1'b0, 8'h81, 1'b0}, 11, "t6");
    tick();
    chk("t6_end_busy", 32'(busy_v[0]), 32'd0);
    chk("t6_end_tx", 32'(tx_v[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
